// File: rtl/sram_dp_be_if.sv
// Dual-port byte-enable SRAM bus: request and read-return signals for ports A and B.
// The master drives requests and the slave (the memory) returns read data.
interface sram_dp_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   addr_a;
    logic [ADDR_WIDTH-1:0]   addr_b;
    logic [DATA_WIDTH-1:0]   data_a;
    logic [DATA_WIDTH-1:0]   data_b;
    logic                    we_a;
    logic                    we_b;
    logic [DATA_WIDTH/8-1:0] be_a;
    logic [DATA_WIDTH/8-1:0] be_b;
    logic                    re_a;
    logic                    re_b;
    logic [DATA_WIDTH-1:0]   q_a;
    logic [DATA_WIDTH-1:0]   q_b;
    logic                    qv_a;
    logic                    qv_b;

    modport master (
        output addr_a, addr_b, data_a, data_b,
        output we_a, we_b, be_a, be_b, re_a, re_b,
        input  q_a, q_b, qv_a, qv_b
    );

    modport slave (
        input  addr_a, addr_b, data_a, data_b,
        input  we_a, we_b, be_a, be_b, re_a, re_b,
        output q_a, q_b, qv_a, qv_b
    );
endinterface

// File: rtl/sram_dp_be.sv
// Byte-addressable dual-port SRAM, write-first, port A wins collisions, pipelined reads.
// Optional registered collision output: define SRAM_DP_BE_COLLISION_FLAG_EN.
module sram_dp_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    sram_dp_be_if.slave  bus
`ifdef SRAM_DP_BE_COLLISION_FLAG_EN
    ,
    output logic         collision
`endif
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr [2];
    logic [DATA_WIDTH-1:0] w_wdat [2];
    logic                  w_we   [2];
    logic [NB-1:0]         w_be   [2];
    logic                  w_re   [2];

    assign w_addr[0] = bus.addr_a;
    assign w_addr[1] = bus.addr_b;
    assign w_wdat[0] = bus.data_a;
    assign w_wdat[1] = bus.data_b;
    assign w_we[0]   = bus.we_a;
    assign w_we[1]   = bus.we_b;
    assign w_be[0]   = bus.be_a;
    assign w_be[1]   = bus.be_b;
    assign w_re[0]   = bus.re_a;
    assign w_re[1]   = bus.re_b;

    // Lane i of a port touches byte addr+i; natural overflow gives the wrap.
    logic [ADDR_WIDTH-1:0] w_laddr [2][NB];
    logic [NB-1:0]         w_wen   [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_wen[p] = '0;
            for (int i = 0; i < NB; i++) begin
                w_laddr[p][i] = w_addr[p] + ADDR_WIDTH'(i);
                w_wen[p][i]   = w_we[p] & w_be[p][i];
            end
        end
    end

    // Write-first read: port B then port A override stored bytes, so A wins.
    logic [DATA_WIDTH-1:0] w_rd [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            for (int i = 0; i < NB; i++) begin
                w_rd[p][8*i +: 8] = r_mem[w_laddr[p][i]];
                for (int s = 1; s >= 0; s--) begin
                    for (int j = 0; j < NB; j++) begin
                        if (w_wen[s][j] && (w_laddr[s][j] == w_laddr[p][i]))
                            w_rd[p][8*i +: 8] = w_wdat[s][8*j +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 1; s >= 0; s--) begin
                for (int j = 0; j < NB; j++) begin
                    if (w_wen[s][j])
                        r_mem[w_laddr[s][j]] <= w_wdat[s][8*j +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_tail_d [2];
    logic                  w_tail_v [2];

    generate
        if (RD_LATENCY == 1) begin : g_direct
            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    w_tail_d[p] = w_rd[p];
                    w_tail_v[p] = w_re[p];
                end
            end
        end else begin : g_pipe
            localparam int NS = RD_LATENCY - 1;

            logic [DATA_WIDTH-1:0] r_pd [2][NS];
            logic [NS-1:0]         r_pv [2];

            always_ff @(posedge clk) begin
                for (int p = 0; p < 2; p++) begin
                    r_pd[p][0] <= w_rd[p];
                    for (int k = 1; k < NS; k++)
                        r_pd[p][k] <= r_pd[p][k-1];
                    if (rst) begin
                        r_pv[p] <= '0;
                    end else begin
                        r_pv[p][0] <= w_re[p];
                        for (int k = 1; k < NS; k++)
                            r_pv[p][k] <= r_pv[p][k-1];
                    end
                end
            end

            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    w_tail_d[p] = r_pd[p][NS-1];
                    w_tail_v[p] = r_pv[p][NS-1];
                end
            end
        end
    endgenerate

    // q holds its last result between valid cycles.
    logic [DATA_WIDTH-1:0] r_q  [2];
    logic                  r_qv [2];

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                r_q[p]  <= '0;
                r_qv[p] <= 1'b0;
            end else begin
                r_qv[p] <= w_tail_v[p];
                if (w_tail_v[p])
                    r_q[p] <= w_tail_d[p];
            end
        end
    end

    assign bus.q_a  = r_q[0];
    assign bus.q_b  = r_q[1];
    assign bus.qv_a = r_qv[0];
    assign bus.qv_b = r_qv[1];

`ifdef SRAM_DP_BE_COLLISION_FLAG_EN
    logic w_coll;
    logic r_collision;

    always_comb begin
        w_coll = 1'b0;
        for (int j = 0; j < NB; j++) begin
            for (int k = 0; k < NB; k++) begin
                if (w_wen[0][j] && w_wen[1][k] &&
                    (w_laddr[0][j] == w_laddr[1][k]))
                    w_coll = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_collision <= 1'b0;
        else
            r_collision <= w_coll;
    end

    assign collision = r_collision;
`endif
endmodule

// File: doc/sram_dp_be.md
SRAM_DP_BE -- requirements
Module: sram_dp_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8, range 8..128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width; memory holds 2**ADDR_WIDTH bytes.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; range 1..3.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock.
REQ-005 rst input 1, synchronous active-high reset.
REQ-006 addr_a, addr_b input ADDR_WIDTH, byte address per port.
REQ-007 data_a, data_b input DATA_WIDTH, write data per port, little-endian.
REQ-008 we_a, we_b input 1, write request per port.
REQ-009 be_a, be_b input DATA_WIDTH/8, byte enables; bit i selects byte lane i at addr+i.
REQ-010 re_a, re_b input 1, read request per port.
REQ-011 q_a, q_b output DATA_WIDTH, read data per port.
REQ-012 qv_a, qv_b output 1, read-data-valid per port.

Function
REQ-013 SHALL be byte-addressable: lane i of a port maps to byte (addr+i) mod 2**ADDR_WIDTH; unaligned addresses permitted; wrap past the top address to byte 0.
REQ-014 SHALL write lane i on the rising edge when we=1 and be[i]=1; lanes with be[i]=0 unchanged; we=1 with be=0 is a no-op.
REQ-015 SHALL sample a read when re=1; q and qv SHALL present that result exactly RD_LATENCY rising edges later, one result per accepted read, fully pipelined (a new read is accepted every cycle).
REQ-016 SHALL hold q at its last value and drive qv=0 in any cycle with no result due.
REQ-017 Same-port read and write in one cycle SHALL be write-first: enabled lanes return new data, disabled lanes return stored data.
REQ-018 Cross-port read of a byte written by the other port in the same cycle SHALL return the new data (write-first across ports).
REQ-019 Both ports writing the same byte in one cycle SHALL resolve to port A's data; non-overlapping bytes from both ports SHALL all be written.
REQ-020 Unwritten bytes SHALL read as X in simulation; no initialisation is performed.
REQ-021 Read pipeline stages beyond the first SHALL be plain registers; no stall or back-pressure.

Reset
REQ-022 rst=1 at a rising edge SHALL clear qv_a, qv_b, q_a, q_b to 0 and flush all in-flight reads (no qv pulse for reads accepted before or during reset).
REQ-023 Reset SHALL NOT alter memory contents; writes with rst=1 SHALL be ignored.
REQ-024 Reads and writes SHALL be accepted from the first rising edge with rst=0.

Configuration
REQ-025 With macro SRAM_DP_BE_COLLISION_FLAG_EN defined, SHALL add output collision 1 (after qv_b), registered, asserted one cycle after any byte is written by both ports in the same cycle, cleared by rst.
REQ-026 Without SRAM_DP_BE_COLLISION_FLAG_EN, port collision SHALL NOT exist; all other behaviour identical.

Verification
REQ-027 RD_LATENCY=1: write 0xDDCCBBAA at addr 0x1000 be=4'hF via A, read 0x1000 via B next cycle -> q_b=0xDDCCBBAA, qv_b=1 one cycle after re_b.
REQ-028 Byte enables/unaligned: after REQ-027, write 0x11223344 at 0x1002 be=4'b0011 -> read 0x1000 returns 0x3344BBAA; read 0x1002 returns 0xXXXX3344 with upper bytes X.
REQ-029 Wrap: ADDR_WIDTH=16, write 0x04030201 at 0xFFFE -> bytes 0xFFFE=01, 0xFFFF=02, 0x0000=03, 0x0001=04; read 0x0000 low half = 0x0403.
REQ-030 Collision: same cycle A writes 0xAAAAAAAA, B writes 0xBBBBBBBB, both at 0x2000 -> read 0x2000 returns 0xAAAAAAAA; with macro, collision=1 for exactly one cycle.
REQ-031 RD_LATENCY=3: back-to-back reads of four addresses on A -> four consecutive qv_a pulses starting 3 cycles after first re_a, data in order; rst asserted in cycle 2 -> no qv_a pulses, q_a=0.
